// File: rtl/mem_responder.sv
// Word-organised on-chip RAM answering one IFU or LSU request at a time,
// LSU first, with a one-cycle response pulse after a fixed latency.
module mem_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        err
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam int          CNT_W     = 16;
  localparam int          WAIT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mem [DEPTH];

  logic               req_lsu;
  logic [31:0]        req_addr;
  logic [1:0]         req_size;
  logic               req_wen;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wmask;

  logic               cur_lsu;
  logic [31:0]        cur_addr;
  logic [1:0]         cur_size;
  logic               cur_wen;
  logic [31:0]        cur_wdata;
  logic [3:0]         cur_wmask;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic               fault;
  logic               enter_resp;
  logic [31:0]        rd_word;
  logic [31:0]        wr_data;
  logic [3:0]         wr_mask;

  function automatic logic [31:0] align_read(input logic [31:0] w, input logic [1:0] ln,
                                             input logic [1:0] sz);
    logic [31:0] s;
    s = w >> {ln, 3'b000};
    case (sz)
      2'd0:    align_read = {24'd0, s[7:0]};
      2'd1:    align_read = {16'd0, s[15:0]};
      default: align_read = s;
    endcase
  endfunction

  // In IDLE the request is decoded straight from the ports (needed when LATENCY is 1);
  // afterwards from the latched copy.
  always_comb begin
    cur_lsu   = req_lsu;
    cur_addr  = req_addr;
    cur_size  = req_size;
    cur_wen   = req_wen;
    cur_wdata = req_wdata;
    cur_wmask = req_wmask;
    if (state == IDLE) begin
      cur_lsu   = io_lsu_reqValid;
      cur_addr  = io_lsu_reqValid ? io_lsu_addr  : io_ifu_addr;
      cur_size  = io_lsu_reqValid ? io_lsu_size  : 2'd2;
      cur_wen   = io_lsu_reqValid & io_lsu_wen;
      cur_wdata = io_lsu_reqValid ? io_lsu_wdata : 32'd0;
      cur_wmask = io_lsu_reqValid ? io_lsu_wmask : 4'd0;
    end
  end

  // IFU requests are decoded as word reads, so the lane check covers them too.
  always_comb begin
    offset  = cur_addr - BASE;
    idx     = offset[IDX_W+1:2];
    lane    = cur_addr[1:0];
    fault   = ({1'b0, offset} >= SPAN) || (cur_size == 2'd3) ||
              (cur_size == 2'd1 && lane[0]) || (cur_size == 2'd2 && lane != 2'd0);
    rd_word = mem[idx];
    wr_data = cur_wdata << {lane, 3'b000};
    wr_mask = cur_wmask << lane;
  end

  assign enter_resp = ((state == IDLE) && (io_lsu_reqValid || io_ifu_reqValid) && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == '0));

  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      req_lsu   <= cur_lsu;
      req_addr  <= cur_addr;
      req_size  <= cur_size;
      req_wen   <= cur_wen;
      req_wdata <= cur_wdata;
      req_wmask <= cur_wmask;
    end
  end

  // Stores commit on the edge leaving RESP; a reset in flight drops them.
  always_ff @(posedge clock) begin
    if (!reset && state == RESP && cur_wen && !fault) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      io_ifu_respValid <= 1'b0;
      io_lsu_respValid <= 1'b0;
      io_ifu_rdata     <= '0;
      io_lsu_rdata     <= '0;
      err              <= 1'b0;
    end else begin
      io_ifu_respValid <= 1'b0;
      io_lsu_respValid <= 1'b0;
      err              <= 1'b0;
      case (state)
        IDLE: if (io_lsu_reqValid || io_ifu_reqValid) begin
          if (LATENCY > 1) begin
            state <= WAIT;
            cnt   <= CNT_W'(WAIT_INIT);
          end else begin
            state <= RESP;
          end
        end
        WAIT: if (cnt == '0) state <= RESP;
              else cnt <= cnt - 1'b1;
        RESP: state <= GAP;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        err <= fault;
        if (cur_lsu) begin
          io_lsu_respValid <= 1'b1;
          io_lsu_rdata     <= (fault || cur_wen) ? 32'd0 : align_read(rd_word, lane, cur_size);
        end else begin
          io_ifu_respValid <= 1'b1;
          io_ifu_rdata     <= fault ? 32'd0 : align_read(rd_word, lane, cur_size);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=2: timing, byte lanes, faults,
// arbitration and reset during a transaction.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_rv;
  logic [31:0] ifu_rdata;
  logic        lsu_req;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rv;
  logic [31:0] lsu_rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(4096), .BASE(32'h8000_0000), .LATENCY(2), .INIT_FILE("")) dut (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(ifu_req), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(ifu_rv), .io_ifu_rdata(ifu_rdata),
    .io_lsu_reqValid(lsu_req), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(lsu_rv), .io_lsu_rdata(lsu_rdata), .err(err)
  );

  // Raises one request in an IDLE cycle, waits (bounded) for its response, then
  // drops the request and lets the GAP cycle pass. lat = -1 means no response.
  task automatic txn(input bit is_lsu, input bit wen, input logic [31:0] addr,
                     input logic [1:0] size, input logic [31:0] wdata, input logic [3:0] wmask,
                     output logic [31:0] rd, output logic e, output int lat, output bit other);
    other = 1'b0; lat = -1; rd = '0; e = 1'b0;
    @(negedge clock);
    if (is_lsu) begin
      lsu_addr = addr; lsu_size = size; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
      lsu_req = 1'b1;
    end else begin
      ifu_addr = addr; ifu_req = 1'b1;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (is_lsu ? ifu_rv : lsu_rv) other = 1'b1;
      if (is_lsu ? lsu_rv : ifu_rv) begin
        lat = c; rd = is_lsu ? lsu_rdata : ifu_rdata; e = err;
        break;
      end
    end
    lsu_req = 1'b0; ifu_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; logic e; int lat; bit other;
    txn(1'b1, 1'b1, addr, 2'd2, data, 4'hF, rd, e, lat, other);
  endtask

  task automatic test_reset;
    reset = 1'b1; ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_addr = 0;
    lsu_size = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    repeat (3) @(negedge clock);
    checks++; if ({ifu_rv, lsu_rv, err} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses: got %b want 000", {ifu_rv, lsu_rv, err}); end
    checks++; if (ifu_rdata !== 32'd0 || lsu_rdata !== 32'd0) begin errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", ifu_rdata, lsu_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_ifu_read;
    logic [31:0] rd; logic e; int lat; bit other;
    txn(1'b1, 1'b1, 32'h8000_0000, 2'd2, 32'h0000_0093, 4'hF, rd, e, lat, other);
    checks++; if (lat !== 2 || rd !== 32'd0 || e !== 1'b0) begin errors++;
      $display("FAIL write_resp: got lat=%0d rd=%h err=%b want lat=2 rd=0 err=0", lat, rd, e); end
    txn(1'b0, 1'b0, 32'h8000_0000, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (lat !== 2) begin errors++;
      $display("FAIL ifu_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'h0000_0093 || e !== 1'b0) begin errors++;
      $display("FAIL ifu_read: got rd=%h err=%b want 00000093 err=0", rd, e); end
    checks++; if (other !== 1'b0) begin errors++;
      $display("FAIL ifu_no_lsu_resp: got %b want 0", other); end
  endtask

  task automatic test_byte_write;
    logic [31:0] rd; logic e; int lat; bit other;
    wr_word(32'h8000_0004, 32'h1122_3344);
    txn(1'b1, 1'b1, 32'h8000_0005, 2'd0, 32'h0000_00AB, 4'b0001, rd, e, lat, other);
    txn(1'b1, 1'b0, 32'h8000_0004, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h1122_AB44 || e !== 1'b0) begin errors++;
      $display("FAIL byte_write: got rd=%h err=%b want 1122ab44 err=0", rd, e); end
    txn(1'b1, 1'b0, 32'h8000_0005, 2'd0, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h0000_00AB) begin errors++;
      $display("FAIL byte_read: got %h want 000000ab", rd); end
    txn(1'b1, 1'b1, 32'h8000_0006, 2'd1, 32'hFFFF_5566, 4'b0011, rd, e, lat, other);
    txn(1'b1, 1'b0, 32'h8000_0004, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h5566_AB44) begin errors++;
      $display("FAIL half_write: got %h want 5566ab44", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic e; int lat; bit other;
    wr_word(32'h8000_0004, 32'hBEEF_1234);
    txn(1'b1, 1'b0, 32'h8000_0006, 2'd1, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h0000_BEEF || e !== 1'b0) begin errors++;
      $display("FAIL half_read: got rd=%h err=%b want 0000beef err=0", rd, e); end
    txn(1'b1, 1'b0, 32'h8000_0006, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'd0 || e !== 1'b1 || lat !== 2) begin errors++;
      $display("FAIL word_misaligned: got rd=%h err=%b lat=%0d want 0 1 2", rd, e, lat); end
    txn(1'b1, 1'b0, 32'h8000_0005, 2'd1, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++;
      $display("FAIL half_misaligned: got rd=%h err=%b want 0 1", rd, e); end
    txn(1'b1, 1'b0, 32'h8000_0004, 2'd3, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++;
      $display("FAIL size3: got rd=%h err=%b want 0 1", rd, e); end
    txn(1'b0, 1'b0, 32'h8000_0006, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++;
      $display("FAIL ifu_misaligned: got rd=%h err=%b want 0 1", rd, e); end
    txn(1'b1, 1'b1, 32'h8000_0006, 2'd2, 32'hFFFF_FFFF, 4'hF, rd, e, lat, other);
    checks++; if (e !== 1'b1) begin errors++;
      $display("FAIL misaligned_write_err: got %b want 1", e); end
    txn(1'b1, 1'b0, 32'h8000_0004, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'hBEEF_1234 || e !== 1'b0) begin errors++;
      $display("FAIL ram_unchanged_misaligned: got rd=%h err=%b want beef1234 0", rd, e); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic e; int lat; bit other;
    txn(1'b1, 1'b0, 32'h7FFF_FFFC, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++;
      $display("FAIL below_base: got rd=%h err=%b want 0 1", rd, e); end
    txn(1'b1, 1'b1, 32'h8000_4000, 2'd2, 32'hCAFE_F00D, 4'hF, rd, e, lat, other);
    checks++; if (e !== 1'b1) begin errors++;
      $display("FAIL above_top_write: got err=%b want 1", e); end
    txn(1'b1, 1'b0, 32'h8000_0000, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h0000_0093) begin errors++;
      $display("FAIL no_alias_write: got %h want 00000093", rd); end
    wr_word(32'h8000_3FFC, 32'h0BAD_CAFE);
    txn(1'b1, 1'b0, 32'h8000_3FFC, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h0BAD_CAFE || e !== 1'b0) begin errors++;
      $display("FAIL last_word: got rd=%h err=%b want 0badcafe 0", rd, e); end
  endtask

  task automatic test_priority;
    int lsu_c = -1, ifu_c = -1;
    logic [31:0] lsu_d = '0, ifu_d = '0;
    @(negedge clock);
    lsu_addr = 32'h8000_0004; lsu_size = 2'd2; lsu_wen = 1'b0; lsu_req = 1'b1;
    ifu_addr = 32'h8000_0000; ifu_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (lsu_rv && lsu_c < 0) begin lsu_c = c; lsu_d = lsu_rdata; lsu_req = 1'b0; end
      if (ifu_rv && ifu_c < 0) begin ifu_c = c; ifu_d = ifu_rdata; ifu_req = 1'b0; end
    end
    lsu_req = 1'b0; ifu_req = 1'b0;
    checks++; if (lsu_c !== 2 || lsu_d !== 32'hBEEF_1234) begin errors++;
      $display("FAIL prio_lsu: got cyc=%0d rd=%h want 2 beef1234", lsu_c, lsu_d); end
    checks++; if (ifu_c !== 6 || ifu_d !== 32'h0000_0093) begin errors++;
      $display("FAIL prio_ifu: got cyc=%0d rd=%h want 6 00000093", ifu_c, ifu_d); end
    checks++; if (lsu_rdata !== 32'hBEEF_1234) begin errors++;
      $display("FAIL lsu_rdata_hold: got %h want beef1234", lsu_rdata); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e; int lat; bit other; bit seen = 1'b0;
    wr_word(32'h8000_000C, 32'h5555_5555);
    txn(1'b1, 1'b0, 32'h8000_000C, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    @(negedge clock);
    lsu_addr = 32'h8000_000C; lsu_size = 2'd2; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_req = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (lsu_rv !== 1'b0 || err !== 1'b0 || lsu_rdata !== 32'd0 || ifu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rv=%b err=%b rd=%h/%h want 0 0 0/0",
               lsu_rv, err, lsu_rdata, ifu_rdata);
    end
    lsu_req = 1'b0;
    repeat (3) begin @(negedge clock); if (lsu_rv || ifu_rv) seen = 1'b1; end
    reset = 1'b0;
    repeat (3) begin @(negedge clock); if (lsu_rv || ifu_rv) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL reset_mid_no_resp: got %b want 0", seen); end
    txn(1'b1, 1'b0, 32'h8000_000C, 2'd2, 32'd0, 4'd0, rd, e, lat, other);
    checks++; if (rd !== 32'h5555_5555 || lat !== 2) begin errors++;
      $display("FAIL reset_mid_ram: got rd=%h lat=%0d want 55555555 2", rd, lat); end
  endtask

  initial begin
    test_reset;
    test_ifu_read;
    test_byte_write;
    test_misaligned;
    test_range;
    test_priority;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
